// File: rtl/pixel_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pixel_write_arbiter_pkg
//   Shared definitions for the pixel write arbiter: VGA coordinate and colour
//   widths, default screen geometry, the arbiter state encoding and the packed
//   pixel record stored in the plot FIFO.
// -----------------------------------------------------------------------------
package pixel_write_arbiter_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    localparam int PIX_W = X_W + Y_W + C_W;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/pixel_write_arbiter_plot_fifo.sv
// -----------------------------------------------------------------------------
// pixel_write_arbiter_plot_fifo
//   Synchronous DEPTH x {x,y,colour} FIFO buffering snake plot requests.
//   DEPTH must be a power of two (>= 2) so the pointers wrap naturally; the
//   occupancy is kept in its own register so full/empty never alias.
//
// Ports
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push_i     write din_i at the tail (ignored while full)
//   pop_i      advance the head (ignored while empty)
//   flush_i    discard every stored entry; a push in the same cycle survives
//   din_i      pixel to store
//   dout_o     pixel at the head (valid while empty_o is low)
//   count_o    current occupancy, 0..DEPTH
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
// -----------------------------------------------------------------------------
module pixel_write_arbiter_plot_fifo
    import pixel_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  pixel_t                 din_i,
    output pixel_t                 dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    pixel_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (flush_i) begin
            // Everything stored before this edge is dropped by jumping the read
            // pointer to the current write slot; a same-cycle push lands there.
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_W'(push_ok);
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_write_arbiter
//   Sits between the snake backend's pixel outputs and the VGA adapter write
//   port. Plot requests are buffered in a small FIFO and drained one per clock.
//   A clear request sweeps every screen pixel to CLEAR_COLOUR in raster order
//   (x inner, y outer); during the sweep the FIFO keeps accepting but does not
//   drain, and entries queued before the sweep started are discarded.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_plot      one-cycle write request with in_x / in_y / in_colour
//   in_ready     FIFO not full; a request while low is dropped
//   clear_req    pulse to start a full-screen clear (ignored while clearing)
//   clear_busy   high for every cycle a sweep pixel is on vga_*
//   clear_done   one-cycle pulse together with the last sweep pixel
//   overflow     sticky flag, set when a request is dropped, cleared by rst
//   fill_level   FIFO occupancy
//   vga_x/y/colour/plot  registered write to the VGA adapter
// -----------------------------------------------------------------------------
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int             DEPTH        = 16,
    parameter int             SCREEN_W     = SCREEN_W_DEF,
    parameter int             SCREEN_H     = SCREEN_H_DEF,
    parameter logic [C_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_plot,
    input  logic [X_W-1:0]         in_x,
    input  logic [Y_W-1:0]         in_y,
    input  logic [C_W-1:0]         in_colour,
    output logic                   in_ready,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot
);

    localparam logic [X_W-1:0] X_LAST    = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST    = Y_W'(SCREEN_H - 1);
    localparam bit             ONE_PIXEL = (SCREEN_W == 1) && (SCREEN_H == 1);

    state_e         state_q;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           sweep_last_d;

    logic [X_W-1:0] vga_x_q;
    logic [Y_W-1:0] vga_y_q;
    logic [C_W-1:0] vga_colour_q;
    logic           vga_plot_q;
    logic           busy_q;
    logic           done_q;
    logic           ovf_q;

    pixel_t         fifo_din;
    pixel_t         fifo_head;
    logic           fifo_full, fifo_empty;
    logic           fifo_pop, fifo_flush;

    // Fullness is judged on the registered count only, so a pop in the same
    // cycle never makes room for a request that arrives while full.
    assign fifo_din   = '{x: in_x, y: in_y, colour: in_colour};
    assign fifo_pop   = (state_q == S_RUN) && !clear_req;
    assign fifo_flush = (state_q == S_RUN) && clear_req;

    pixel_write_arbiter_plot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_plot),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (fifo_din),
        .dout_o  (fifo_head),
        .count_o (fill_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // cx_q/cy_q track the sweep pixel currently on vga_*; *_d is the one after it.
    always_comb begin
        cx_d = cx_q + X_W'(1);
        cy_d = cy_q;
        if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = (cy_q == Y_LAST) ? '0 : cy_q + Y_W'(1);
        end
        sweep_last_d = (cx_d == X_LAST) && (cy_d == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            cx_q         <= '0;
            cy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (in_plot && fifo_full) begin
                ovf_q <= 1'b1;
            end
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (clear_req) begin
                        // The first sweep pixel goes out on the same edge the
                        // clear is accepted, so busy covers exactly W*H cycles.
                        cx_q         <= '0;
                        cy_q         <= '0;
                        vga_x_q      <= '0;
                        vga_y_q      <= '0;
                        vga_colour_q <= CLEAR_COLOUR;
                        vga_plot_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        if (ONE_PIXEL) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_CLEAR;
                        end
                    end else begin
                        busy_q     <= 1'b0;
                        vga_plot_q <= ~fifo_empty;
                        if (!fifo_empty) begin
                            vga_x_q      <= fifo_head.x;
                            vga_y_q      <= fifo_head.y;
                            vga_colour_q <= fifo_head.colour;
                        end
                    end
                end
                S_CLEAR: begin
                    cx_q         <= cx_d;
                    cy_q         <= cy_d;
                    vga_x_q      <= cx_d;
                    vga_y_q      <= cy_d;
                    vga_colour_q <= CLEAR_COLOUR;
                    vga_plot_q   <= 1'b1;
                    busy_q       <= 1'b1;
                    // Leave S_CLEAR while the last pixel is being shown so the
                    // FIFO starts draining on the following edge.
                    if (sweep_last_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign in_ready   = ~fifo_full;
    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign overflow   = ovf_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_arbiter
//   Directed scenarios plus randomized traffic for pixel_write_arbiter, with a
//   queue-based reference model of the arbiter's behaviour checked every cycle.
// -----------------------------------------------------------------------------
module tb_pixel_write_arbiter;

    localparam int DEPTH = 16;
    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int NPIX  = SW * SH;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_plot;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       in_ready;
    logic       clear_req;
    logic       clear_busy;
    logic       clear_done;
    logic       overflow;
    logic [4:0] fill_level;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    pixel_write_arbiter #(
        .DEPTH        (DEPTH),
        .SCREEN_W     (SW),
        .SCREEN_H     (SH),
        .CLEAR_COLOUR (3'b000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_plot    (in_plot),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_ready   (in_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .overflow   (overflow),
        .fill_level (fill_level),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, clear progress as a linear
    // pixel index converted to (x,y) with division/modulo.
    pix_t       mq[$];
    bit         m_clearing = 1'b0;
    int         m_idx      = 0;
    logic       e_plot = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;
    logic [7:0] e_x = '0;
    logic [6:0] e_y = '0;
    logic [2:0] e_c = '0;

    // Observation helpers filled in every cycle.
    pix_t outq[$];
    int   done_cnt  = 0;
    int   sweep_cnt = 0;
    int   bad_seen  = 0;

    task automatic model_step();
        bit   acc;
        pix_t np;
        pix_t h;
        if (rst) begin
            mq.delete();
            m_clearing = 1'b0;
            m_idx  = 0;
            e_plot = 1'b0; e_x = '0; e_y = '0; e_c = '0;
            e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
        end else begin
            acc = in_plot && (mq.size() < DEPTH);
            if (in_plot && !acc) e_ovf = 1'b1;
            np = '{x: in_x, y: in_y, c: in_colour};
            e_done = 1'b0;
            if (m_clearing) begin
                m_idx++;
                e_plot = 1'b1;
                e_x = 8'(m_idx % SW);
                e_y = 7'(m_idx / SW);
                e_c = 3'b000;
                e_busy = 1'b1;
                if (m_idx == NPIX - 1) begin
                    e_done = 1'b1;
                    m_clearing = 1'b0;
                end
            end else if (clear_req) begin
                mq.delete();
                m_clearing = 1'b1;
                m_idx  = 0;
                e_plot = 1'b1; e_x = '0; e_y = '0; e_c = 3'b000;
                e_busy = 1'b1;
            end else begin
                e_busy = 1'b0;
                if (mq.size() > 0) begin
                    h = mq.pop_front();
                    e_plot = 1'b1; e_x = h.x; e_y = h.y; e_c = h.c;
                end else begin
                    e_plot = 1'b0;
                end
            end
            if (acc) mq.push_back(np);
        end
    endtask

    // One clock: the model consumes the inputs seen at the edge, outputs are
    // sampled on the falling edge and compared in full.
    task automatic tick();
        logic [27:0] obs;
        logic [27:0] exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        obs = {vga_plot, vga_x, vga_y, vga_colour, clear_busy, clear_done,
               overflow, in_ready, fill_level};
        exp = {e_plot, e_x, e_y, e_c, e_busy, e_done, e_ovf,
               (mq.size() < DEPTH), 5'(mq.size())};
        check("cycle", 32'(obs), 32'(exp));
        if (vga_plot && !clear_busy) outq.push_back('{x: vga_x, y: vga_y, c: vga_colour});
        if (clear_done) done_cnt++;
        if (clear_busy && vga_plot) sweep_cnt++;
        if (vga_plot && vga_x >= 8'd200) bad_seen++;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < NPIX + 16; i++) begin
            tick();
            if (clear_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int maxfill;
        rst = 1'b1; in_plot = 1'b0; in_x = '0; in_y = '0; in_colour = '0; clear_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_plot",  32'(vga_plot), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_fill",  32'(fill_level), 32'd0);
        check("rst_flags", 32'({clear_busy, clear_done, overflow}), 32'd0);

        // Single push: visible only after the second edge.
        in_plot = 1'b1; in_x = 8'd10; in_y = 7'd20; in_colour = 3'b100;
        tick();
        in_plot = 1'b0;
        check("t1_not_yet", 32'(vga_plot), 32'd0);
        check("t1_fill",    32'(fill_level), 32'd1);
        tick();
        check("t1_pix", 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'({1'b1, 8'd10, 7'd20, 3'd4}));
        tick();
        check("t1_idle", 32'(vga_plot), 32'd0);
        check("t1_hold", 32'({vga_x, vga_y, vga_colour}), 32'({8'd10, 7'd20, 3'd4}));

        // Burst of 20 back-to-back pushes.
        outq.delete();
        maxfill = 0;
        for (int i = 0; i < 20; i++) begin
            in_plot = 1'b1; in_x = 8'(i + 30); in_y = 7'(i); in_colour = 3'(i);
            tick();
            if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
        end
        in_plot = 1'b0;
        tick();
        tick();
        check("t2_count",   32'(outq.size()), 32'd20);
        for (int i = 0; i < 20 && i < outq.size(); i++)
            check("t2_order", 32'(outq[i]), 32'({8'(i + 30), 7'(i), 3'(i)}));
        check("t2_maxfill", 32'(maxfill), 32'd1);
        check("t2_ovf",     32'(overflow), 32'd0);

        // Clear with 17 pushes during the sweep; extra clear_req pulses are ignored.
        sweep_cnt = 0; done_cnt = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t4_first", 32'({vga_plot, vga_x, vga_y, vga_colour, clear_busy}),
              32'({1'b1, 8'd0, 7'd0, 3'd0, 1'b1}));
        for (int i = 0; i < 17; i++) begin
            in_plot = 1'b1; in_x = 8'(100 + i); in_y = 7'(i); in_colour = 3'(i);
            clear_req = ($urandom_range(0, 3) == 0);
            tick();
            in_plot = 1'b0; clear_req = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        check("t4_ovf",   32'(overflow), 32'd1);
        check("t4_ready", 32'(in_ready), 32'd0);
        check("t4_fill",  32'(fill_level), 32'd16);
        outq.delete();
        wait_done("t4_done_seen");
        check("t4_last",     32'({vga_x, vga_y}), 32'({8'd159, 7'd119}));
        check("t4_sweeplen", 32'(sweep_cnt), NPIX);
        repeat (18) tick();
        check("t4_done_once", 32'(done_cnt), 32'd1);
        check("t4_drained",   32'(outq.size()), 32'd16);
        for (int i = 0; i < 16 && i < outq.size(); i++)
            check("t4_order", 32'(outq[i]), 32'({8'(100 + i), 7'(i), 3'(i)}));

        // Clear with 5 entries queued, then a new clear + push at the done cycle.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(1, 6)) tick();
            in_plot = 1'b1; in_x = 8'(200 + i); in_y = 7'($urandom_range(0, 127));
            in_colour = 3'($urandom_range(0, 7));
            tick();
            in_plot = 1'b0;
        end
        wait_done("t3_prev_done_seen");
        check("t5_fill_before", 32'(fill_level), 32'd5);
        sweep_cnt = 0; done_cnt = 0;
        clear_req = 1'b1; in_plot = 1'b1; in_x = 8'd7; in_y = 7'd7; in_colour = 3'b010;
        tick();
        clear_req = 1'b0; in_plot = 1'b0;
        check("t5_fill_after", 32'(fill_level), 32'd1);
        check("t3_first", 32'({vga_plot, vga_x, vga_y, vga_colour, clear_busy}),
              32'({1'b1, 8'd0, 7'd0, 3'd0, 1'b1}));
        wait_done("t3_done_seen");
        check("t3_last",     32'({vga_x, vga_y, vga_colour}), 32'({8'd159, 7'd119, 3'd0}));
        check("t3_sweeplen", 32'(sweep_cnt), NPIX);
        tick();
        check("t5_kept", 32'({vga_plot, vga_x, vga_y, vga_colour, clear_busy}),
              32'({1'b1, 8'd7, 7'd7, 3'd2, 1'b0}));
        repeat (4) tick();
        check("t3_done_once", 32'(done_cnt), 32'd1);
        check("t3_flushed",   32'(bad_seen), 32'd0);

        // Reset in the middle of a sweep.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (5000) tick();
        check("t6_at5000", 32'({clear_busy, vga_x, vga_y}), 32'({1'b1, 8'd40, 7'd31}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst", 32'({vga_plot, vga_x, vga_y, vga_colour, clear_busy, clear_done, overflow, fill_level}), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        done_cnt = 0;
        repeat (30) tick();
        check("t6_no_done", 32'(done_cnt), 32'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t6_restart", 32'({vga_plot, vga_x, vga_y, clear_busy}), 32'({1'b1, 8'd0, 7'd0, 1'b1}));
        tick();
        check("t6_second", 32'({vga_x, vga_y}), 32'({8'd1, 7'd0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_plot   = $urandom_range(0, 1) == 1;
            in_x      = 8'($urandom_range(0, 255));
            in_y      = 7'($urandom_range(0, 127));
            in_colour = 3'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; in_plot = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
